// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing controller: load-use, multi-cycle EX and branch flush control
module pipe_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_PCTL,
  input  logic             rst_PCTL,
  input  logic [4:0]       id_rs_PCTL,
  input  logic [4:0]       id_rt_PCTL,
  input  logic             id_usesRt_PCTL,
  input  logic [4:0]       ex_rd_PCTL,
  input  logic             ex_memRead_PCTL,
  input  logic             ex_mcStart_PCTL,
  input  logic             br_taken_PCTL,
  output logic             pcEn_PCTL,
  output logic             bf0En_PCTL,
  output logic             bf0Flush_PCTL,
  output logic             bf1En_PCTL,
  output logic             bf1Bubble_PCTL,
  output logic             mcBusy_PCTL,
  output logic [CNT_W-1:0] stallCnt_PCTL
);

  localparam int MW      = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam int MC_LOAD = (MC_LAT >= 2) ? (MC_LAT - 2) : 0;
  localparam logic [MW-1:0] MC_LOAD_V = MW'(MC_LOAD);
  localparam bit MC_STALLS = (MC_LAT >= 2);

  typedef enum logic {
    RUN,
    MC_WAIT
  } state_t;

  state_t        state, state_next;
  logic [MW-1:0] mc_cnt, mc_cnt_next;
  logic          lu;

  // Register $0 is hardwired, so a load targeting it can never create a hazard.
  assign lu = ex_memRead_PCTL && (ex_rd_PCTL != 5'd0) &&
              ((ex_rd_PCTL == id_rs_PCTL) ||
               (id_usesRt_PCTL && (ex_rd_PCTL == id_rt_PCTL)));

  always_ff @(posedge clk_PCTL) begin
    if (rst_PCTL) begin
      state         <= RUN;
      mc_cnt        <= '0;
      stallCnt_PCTL <= '0;
    end else begin
      state  <= state_next;
      mc_cnt <= mc_cnt_next;
      if (!pcEn_PCTL && (stallCnt_PCTL != {CNT_W{1'b1}}))
        stallCnt_PCTL <= stallCnt_PCTL + 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    mc_cnt_next    = mc_cnt;
    pcEn_PCTL      = 1'b1;
    bf0En_PCTL     = 1'b1;
    bf0Flush_PCTL  = 1'b0;
    bf1En_PCTL     = 1'b1;
    bf1Bubble_PCTL = 1'b0;
    mcBusy_PCTL    = 1'b0;
    if (rst_PCTL) begin
      pcEn_PCTL  = 1'b0;
      bf0En_PCTL = 1'b0;
      bf1En_PCTL = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (br_taken_PCTL) begin
            bf0Flush_PCTL  = 1'b1;
            bf1Bubble_PCTL = 1'b1;
          end else if (ex_mcStart_PCTL && MC_STALLS) begin
            pcEn_PCTL   = 1'b0;
            bf0En_PCTL  = 1'b0;
            bf1En_PCTL  = 1'b0;
            mcBusy_PCTL = 1'b1;
            mc_cnt_next = MC_LOAD_V;
            state_next  = MC_WAIT;
          end else if (lu) begin
            pcEn_PCTL      = 1'b0;
            bf0En_PCTL     = 1'b0;
            bf1Bubble_PCTL = 1'b1;
          end
        end
        MC_WAIT: begin
          // The held op keeps ex_mcStart high, so only the counter decides release.
          if (mc_cnt != '0) begin
            pcEn_PCTL   = 1'b0;
            bf0En_PCTL  = 1'b0;
            bf1En_PCTL  = 1'b0;
            mcBusy_PCTL = 1'b1;
            mc_cnt_next = mc_cnt - 1'b1;
          end else begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_mem_read, ex_mc_start, br_taken;

  logic        a_pc, a_b0, a_f0, a_b1, a_bb, a_mc;
  logic [15:0] a_cnt;
  logic        b_pc, b_b0, b_f0, b_b1, b_bb, b_mc;
  logic [2:0]  b_cnt;
  logic        c_pc, c_b0, c_f0, c_b1, c_bb, c_mc;
  logic [15:0] c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] CTL_DEF = 6'b110100;
  localparam logic [5:0] CTL_BR  = 6'b111110;
  localparam logic [5:0] CTL_MC  = 6'b000001;
  localparam logic [5:0] CTL_LU  = 6'b000110;
  localparam logic [5:0] CTL_RST = 6'b000000;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_LAT(4), .CNT_W(16)) dut_a (
    .clk_PCTL(clk), .rst_PCTL(rst), .id_rs_PCTL(id_rs), .id_rt_PCTL(id_rt),
    .id_usesRt_PCTL(id_uses_rt), .ex_rd_PCTL(ex_rd), .ex_memRead_PCTL(ex_mem_read),
    .ex_mcStart_PCTL(ex_mc_start), .br_taken_PCTL(br_taken),
    .pcEn_PCTL(a_pc), .bf0En_PCTL(a_b0), .bf0Flush_PCTL(a_f0), .bf1En_PCTL(a_b1),
    .bf1Bubble_PCTL(a_bb), .mcBusy_PCTL(a_mc), .stallCnt_PCTL(a_cnt)
  );

  pipe_ctrl #(.MC_LAT(4), .CNT_W(3)) dut_b (
    .clk_PCTL(clk), .rst_PCTL(rst), .id_rs_PCTL(id_rs), .id_rt_PCTL(id_rt),
    .id_usesRt_PCTL(id_uses_rt), .ex_rd_PCTL(ex_rd), .ex_memRead_PCTL(ex_mem_read),
    .ex_mcStart_PCTL(ex_mc_start), .br_taken_PCTL(br_taken),
    .pcEn_PCTL(b_pc), .bf0En_PCTL(b_b0), .bf0Flush_PCTL(b_f0), .bf1En_PCTL(b_b1),
    .bf1Bubble_PCTL(b_bb), .mcBusy_PCTL(b_mc), .stallCnt_PCTL(b_cnt)
  );

  pipe_ctrl #(.MC_LAT(1), .CNT_W(16)) dut_c (
    .clk_PCTL(clk), .rst_PCTL(rst), .id_rs_PCTL(id_rs), .id_rt_PCTL(id_rt),
    .id_usesRt_PCTL(id_uses_rt), .ex_rd_PCTL(ex_rd), .ex_memRead_PCTL(ex_mem_read),
    .ex_mcStart_PCTL(ex_mc_start), .br_taken_PCTL(br_taken),
    .pcEn_PCTL(c_pc), .bf0En_PCTL(c_b0), .bf0Flush_PCTL(c_f0), .bf1En_PCTL(c_b1),
    .bf1Bubble_PCTL(c_bb), .mcBusy_PCTL(c_mc), .stallCnt_PCTL(c_cnt)
  );

  wire [5:0] a_ctl = {a_pc, a_b0, a_f0, a_b1, a_bb, a_mc};
  wire [5:0] c_ctl = {c_pc, c_b0, c_f0, c_b1, c_bb, c_mc};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_mc_start = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    settle();
    check("rst_ctl", 32'(a_ctl), 32'(CTL_RST));
    tick();
    tick();
    check("rst_cnt", 32'(a_cnt), 32'd0);
    rst = 1'b0;
    settle();
    check("idle_ctl", 32'(a_ctl), 32'(CTL_DEF));

    // load-use on rs
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    settle();
    check("lu_rs_ctl", 32'(a_ctl), 32'(CTL_LU));
    tick();
    clear_inputs();
    settle();
    check("lu_after_ctl", 32'(a_ctl), 32'(CTL_DEF));
    check("lu_cnt", 32'(a_cnt), 32'd1);

    // no false hazards
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    settle();
    check("rd0_ctl", 32'(a_ctl), 32'(CTL_DEF));
    ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
    settle();
    check("rt_unused_ctl", 32'(a_ctl), 32'(CTL_DEF));
    tick();
    check("no_hazard_cnt", 32'(a_cnt), 32'd1);
    id_uses_rt = 1'b1;
    settle();
    check("lu_rt_ctl", 32'(a_ctl), 32'(CTL_LU));
    tick();
    clear_inputs();
    settle();
    check("lu_rt_cnt", 32'(a_cnt), 32'd2);

    // two back-to-back multi-cycle ops, MC_LAT=4
    ex_mc_start = 1'b1;
    settle();
    check("mc1_c_nostall", 32'(c_ctl), 32'(CTL_DEF));
    for (int op = 0; op < 2; op++) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("mc%0d_stall%0d", op, k), 32'(a_ctl), 32'(CTL_MC));
        tick();
        settle();
      end
      check($sformatf("mc%0d_release", op), 32'(a_ctl), 32'(CTL_DEF));
      tick();
      settle();
    end
    check("mc_cnt", 32'(a_cnt), 32'd8);
    check("mc_c_cnt", 32'(c_cnt), 32'd2);
    // held start is a third op; let it run out
    for (int k = 0; k < 4; k++) tick();
    ex_mc_start = 1'b0;
    settle();
    check("mc3_cnt", 32'(a_cnt), 32'd11);

    // branch beats load-use
    br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    settle();
    check("br_ctl", 32'(a_ctl), 32'(CTL_BR));
    tick();
    clear_inputs();
    settle();
    check("br_cnt", 32'(a_cnt), 32'd11);

    // reset in the middle of a multi-cycle wait
    ex_mc_start = 1'b1;
    settle();
    check("mcr_t_ctl", 32'(a_ctl), 32'(CTL_MC));
    tick();
    rst = 1'b1;
    settle();
    check("mcr_rst_ctl", 32'(a_ctl), 32'(CTL_RST));
    tick();
    rst = 1'b0;
    ex_mc_start = 1'b0;
    settle();
    check("mcr_after_ctl", 32'(a_ctl), 32'(CTL_DEF));
    check("mcr_after_cnt", 32'(a_cnt), 32'd0);
    tick();
    check("mcr_idle_cnt", 32'(a_cnt), 32'd0);

    // saturation: 12 cycles of held ops give 9 stalls, CNT_W=3 sticks at 7
    ex_mc_start = 1'b1;
    settle();
    check("sat_fresh_ctl", 32'(a_ctl), 32'(CTL_MC));
    for (int k = 0; k < 12; k++) tick();
    ex_mc_start = 1'b0;
    settle();
    check("sat_wide_cnt", 32'(a_cnt), 32'd9);
    check("sat_narrow_cnt", 32'(b_cnt), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
